// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin share of one multi-cycle shifter between ALU (A) and LSU align (B)
// Optional: define SHIFT_ZERO_BYPASS_EN to answer amt==0 requests without touching the shifter.
module shift_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_valid,
  output logic        o_a_accept,
  input  logic [31:0] i_a_op1,
  input  logic [4:0]  i_a_amt,
  input  logic [1:0]  i_a_dir,
  output logic        o_a_done,
  output logic [31:0] o_a_result,
  input  logic        i_b_valid,
  output logic        o_b_accept,
  input  logic [31:0] i_b_op1,
  input  logic [4:0]  i_b_amt,
  input  logic [1:0]  i_b_dir,
  output logic        o_b_done,
  output logic [31:0] o_b_result,
  output logic [31:0] o_sh_op1,
  output logic [4:0]  o_sh_amt,
  output logic [1:0]  o_sh_dir,
  output logic        o_sh_start,
  input  logic [31:0] i_sh_result,
  input  logic        i_sh_ready,
  output logic        o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;     // 0: A wins a tie, 1: B wins a tie
  logic        owner_q, owner_d;   // 0: A, 1: B
  logic [31:0] op1_q, op1_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  dir_q, dir_d;
  logic        busy_seen_q, busy_seen_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0] a_res_q, a_res_d;
  logic [31:0] b_res_q, b_res_d;
  logic        timeout_q, timeout_d;

  logic        grant_a, grant_b;
  logic [31:0] win_op1;
  logic [4:0]  win_amt;
  logic [1:0]  win_dir;
  logic        bypass;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE && i_rst_n && i_sh_ready) begin
      if (i_a_valid && (!i_b_valid || !prio_q)) begin
        grant_a = 1'b1;
      end else if (i_b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign win_op1 = grant_b ? i_b_op1 : i_a_op1;
  assign win_amt = grant_b ? i_b_amt : i_a_amt;
  assign win_dir = grant_b ? i_b_dir : i_a_dir;

`ifdef SHIFT_ZERO_BYPASS_EN
  assign bypass = (win_amt == 5'd0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op1_d       = op1_q;
    amt_d       = amt_q;
    dir_d       = dir_q;
    busy_seen_d = busy_seen_q;
    cnt_d       = cnt_q;
    a_res_d     = a_res_q;
    b_res_d     = b_res_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          owner_d = grant_b;
          op1_d   = win_op1;
          amt_d   = win_amt;
          dir_d   = win_dir;
          if (bypass) begin
            if (grant_b) b_res_d = win_op1;
            else         a_res_d = win_op1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        busy_seen_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (!i_sh_ready) busy_seen_d = 1'b1;
        // Ready seen before the shifter ever went busy is stale and ignored.
        if (busy_seen_q && i_sh_ready) begin
          if (owner_q) b_res_d = i_sh_result;
          else         a_res_d = i_sh_result;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          if (owner_q) b_res_d = '0;
          else         a_res_d = '0;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        prio_d  = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      op1_q       <= '0;
      amt_q       <= '0;
      dir_q       <= '0;
      busy_seen_q <= 1'b0;
      cnt_q       <= '0;
      a_res_q     <= '0;
      b_res_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      op1_q       <= op1_d;
      amt_q       <= amt_d;
      dir_q       <= dir_d;
      busy_seen_q <= busy_seen_d;
      cnt_q       <= cnt_d;
      a_res_q     <= a_res_d;
      b_res_q     <= b_res_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_a_accept = grant_a;
  assign o_b_accept = grant_b;
  assign o_a_done   = (state_q == S_RESP) && !owner_q;
  assign o_b_done   = (state_q == S_RESP) &&  owner_q;
  assign o_a_result = a_res_q;
  assign o_b_result = b_res_q;
  assign o_sh_op1   = op1_q;
  assign o_sh_amt   = amt_q;
  assign o_sh_dir   = dir_q;
  assign o_sh_start = (state_q == S_ISSUE);
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed bench for shift_arbiter with mock shifter and transaction-level model
module tb_shift_arbiter;
  localparam int TIMEOUT  = 16;
  localparam int M_NORMAL = 0;
  localparam int M_NODROP = 1;
  localparam int M_NORET  = 2;

  typedef struct packed {
    logic [31:0] op1;
    logic [4:0]  amt;
    logic [1:0]  dir;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_valid = 0, b_valid = 0, a_accept, b_accept, a_done, b_done;
  logic [31:0] a_op1 = 0, b_op1 = 0, a_result, b_result;
  logic [4:0]  a_amt = 0, b_amt = 0, sh_amt;
  logic [1:0]  a_dir = 0, b_dir = 0, sh_dir;
  logic [31:0] sh_op1, sh_result = 0;
  logic        sh_start, sh_ready = 1, timeout;

  shift_arbiter #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_accept(a_accept), .i_a_op1(a_op1), .i_a_amt(a_amt),
    .i_a_dir(a_dir), .o_a_done(a_done), .o_a_result(a_result),
    .i_b_valid(b_valid), .o_b_accept(b_accept), .i_b_op1(b_op1), .i_b_amt(b_amt),
    .i_b_dir(b_dir), .o_b_done(b_done), .o_b_result(b_result),
    .o_sh_op1(sh_op1), .o_sh_amt(sh_amt), .o_sh_dir(sh_dir), .o_sh_start(sh_start),
    .i_sh_result(sh_result), .i_sh_ready(sh_ready), .o_timeout(timeout)
  );

  int tests_run = 0, fails = 0, cyc = 0;
  op_t qa[$], qb[$];
  int sh_mode = M_NORMAL, sh_lat = 3, busy_left = 0;

  // Transaction model: one outstanding op with predicted start/done cycles.
  logic        m_busy = 0, m_owner = 0, m_byp = 0, m_to = 0, m_prio = 0, m_timeout = 0;
  int          m_start = 0, m_done = 0;
  op_t         m_op;
  logic [31:0] m_val = 0, m_res_a = 0, m_res_b = 0;

  int last_acc = 0, last_start = 0, last_done = 0, n_starts = 0, n_bdone = 0;
  bit glog[$];

  function automatic op_t mk(logic [31:0] op1, logic [4:0] amt, logic [1:0] dir);
    op_t o;
    o.op1 = op1; o.amt = amt; o.dir = dir;
    return o;
  endfunction

  function automatic logic [31:0] shf(op_t o);
    logic [31:0] r;
    if (o.dir == 2'd0)      r = o.op1 << o.amt;
    else if (o.dir == 2'd1) r = o.op1 >> o.amt;
    else if (o.dir == 2'd2) r = $unsigned($signed(o.op1) >>> o.amt);
    else                    r = (o.op1 << o.amt) | (o.op1 >> (32 - int'(o.amt)));
    return r;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    logic ga, gb, dn;
    op_t  w;
    @(negedge clk);
    cyc++;
    if (sh_mode == M_NODROP) sh_ready = 1'b1;
    else if (busy_left > 0) begin
      sh_ready = 1'b0;
      if (sh_mode != M_NORET) busy_left--;
    end else sh_ready = 1'b1;
    if (sh_start) begin
      busy_left = (sh_mode == M_NODROP) ? 0 : ((sh_mode == M_NORET) ? 1 : sh_lat);
      sh_result = shf(mk(sh_op1, sh_amt, sh_dir));
    end
    a_valid = (qa.size() > 0);
    if (a_valid) {a_op1, a_amt, a_dir} = qa[0];
    else {a_op1, a_amt, a_dir} = {$urandom, 7'($urandom)};
    b_valid = (qb.size() > 0);
    if (b_valid) {b_op1, b_amt, b_dir} = qb[0];
    else {b_op1, b_amt, b_dir} = {$urandom, 7'($urandom)};
    #1;
    dn = m_busy && (cyc == m_done);
    if (dn) begin
      if (m_owner) m_res_b = m_val; else m_res_a = m_val;
      if (m_to) m_timeout = 1'b1;
    end
    ga = 1'b0; gb = 1'b0;
    if (!m_busy && sh_ready) begin
      if (a_valid && (!b_valid || !m_prio)) ga = 1'b1;
      else if (b_valid) gb = 1'b1;
    end
    check("a_accept", a_accept, ga);
    check("b_accept", b_accept, gb);
    check("sh_start", sh_start, m_busy && !m_byp && cyc == m_start);
    check("a_done", a_done, dn && !m_owner);
    check("b_done", b_done, dn && m_owner);
    check("a_result", a_result, m_res_a);
    check("b_result", b_result, m_res_b);
    check("timeout", timeout, m_timeout);
    if (m_busy && !m_byp && cyc >= m_start) begin
      check("sh_op1", sh_op1, m_op.op1);
      check("sh_amt", sh_amt, m_op.amt);
      check("sh_dir", sh_dir, m_op.dir);
    end
    if (dn) begin
      m_prio = ~m_owner;
      m_busy = 1'b0;
    end
    if (ga || gb) begin
      w = gb ? qb.pop_front() : qa.pop_front();
      m_busy = 1'b1; m_owner = gb; m_op = w; m_start = cyc + 1;
      m_byp = 1'b0; m_to = 1'b0;
`ifdef SHIFT_ZERO_BYPASS_EN
      if (w.amt == 5'd0) begin
        m_byp = 1'b1; m_done = cyc + 1; m_val = w.op1;
      end else
`endif
      if (sh_mode == M_NORMAL && sh_lat >= 1 && sh_lat <= TIMEOUT - 1) begin
        m_done = cyc + sh_lat + 3; m_val = shf(w);
      end else begin
        m_done = cyc + TIMEOUT + 2; m_val = '0; m_to = 1'b1;
      end
    end
    if (a_accept || b_accept) begin last_acc = cyc; glog.push_back(b_accept); end
    if (sh_start) begin last_start = cyc; n_starts++; end
    if (a_done || b_done) last_done = cyc;
    if (b_done) n_bdone++;
  endtask

  task automatic run_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!m_busy && qa.size() == 0 && qb.size() == 0) return;
    end
    check("idle_within_budget", 0, 1);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_a_accept", a_accept, 0);
    check("rst_b_accept", b_accept, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    check("rst_a_result", a_result, 0);
    check("rst_b_result", b_result, 0);
    check("rst_sh_op1", sh_op1, 0);
    check("rst_sh_amt", sh_amt, 0);
    check("rst_sh_dir", sh_dir, 0);
    check("rst_sh_start", sh_start, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete(); glog.delete();
    sh_mode = M_NORMAL; busy_left = 0; sh_ready = 1'b1;
    m_busy = 0; m_prio = 0; m_timeout = 0; m_res_a = 0; m_res_b = 0;
  endtask

  initial begin
    logic [5:0] seq;
    int s0;
    do_reset();

    // A only, shifter busy 3 cycles
    sh_lat = 3;
    qa.push_back(mk(32'h0000_00F0, 5'd4, 2'd0));
    run_idle(40);
    check("t1_result", a_result, 32'h0000_0F00);
    check("t1_start_lat", last_start - last_acc, 1);
    check("t1_done_lat", last_done - last_acc, 6);
    check("t1_no_b_done", n_bdone, 0);

    // simultaneous A and B after reset
    do_reset();
    sh_lat = 2;
    qa.push_back(mk(32'h8000_0001, 5'd1, 2'd3));
    qb.push_back(mk(32'hF000_0000, 5'd8, 2'd2));
    run_idle(60);
    check("t2_order", {glog[0], glog[1]}, 2'b01);
    check("t2_b_result", b_result, 32'hFFF0_0000);

    // continuous contention, 6 ops
    glog.delete();
    sh_lat = 1;
    s0 = n_starts;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk(32'h1234_5678 + i, 5'(i + 1), 2'(i)));
      qb.push_back(mk(32'h0F0F_0F0F ^ i, 5'(31 - i), 2'(i + 1)));
    end
    run_idle(100);
    seq = '0;
    foreach (glog[i]) seq = {seq[4:0], glog[i]};
    check("t3_grant_seq", seq, 6'b010101);
    check("t3_starts", n_starts - s0, 6);

    // timeouts: ready never drops, then ready never returns
    sh_mode = M_NODROP;
    qa.push_back(mk(32'hAAAA_5555, 5'd3, 2'd1));
    run_idle(60);
    check("t4_wait_cycles", last_done - last_start, 17);
    check("t4_a_result", a_result, 32'h0);
    check("t4_timeout", timeout, 1);
    sh_mode = M_NORET;
    qb.push_back(mk(32'h1357_9BDF, 5'd5, 2'd0));
    run_idle(60);
    check("t4b_wait_cycles", last_done - last_start, 17);
    sh_mode = M_NORMAL; busy_left = 0; sh_lat = 2;
    qa.push_back(mk(32'h0000_0003, 5'd2, 2'd0));
    run_idle(60);
    check("t4_good_result", a_result, 32'h0000_000C);
    check("t4_sticky", timeout, 1);

    // reset while B is in WAIT
    sh_lat = 8;
    qb.push_back(mk(32'hCAFE_F00D, 5'd4, 2'd1));
    for (int i = 0; i < 20 && !(m_busy && !m_byp && cyc >= m_start + 2); i++) tick();
    check("t5_in_wait", m_busy && !m_byp && cyc >= m_start + 2, 1);
    do_reset();
    sh_lat = 2;
    qa.push_back(mk(32'h0000_0001, 5'd31, 2'd0));
    qb.push_back(mk(32'h8000_0000, 5'd31, 2'd1));
    run_idle(60);
    check("t5_order", {glog[0], glog[1]}, 2'b01);
    check("t5_a_result", a_result, 32'h8000_0000);
    check("t5_b_result", b_result, 32'h0000_0001);

    // amt == 0
    s0 = n_starts;
    qa.push_back(mk(32'hDEAD_BEEF, 5'd0, 2'd0));
    run_idle(40);
    check("t6_result", a_result, 32'hDEAD_BEEF);
`ifdef SHIFT_ZERO_BYPASS_EN
    check("t6_done_lat", last_done - last_acc, 1);
    check("t6_no_start", n_starts - s0, 0);
`else
    check("t6_done_lat", last_done - last_acc, 5);
    check("t6_start", n_starts - s0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
